// File: rtl/obi_axi_bridge.sv
// OBI slave to AXI4 master bridge: single-beat transfers, several outstanding
// requests of one direction at a time, responses returned to OBI in order.
module obi_axi_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  localparam int BE_W   = DATA_W / 8,
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  // OBI slave
  input  logic              obi_req_i,
  input  logic              obi_we_i,
  input  logic [BE_W-1:0]   obi_be_i,
  input  logic [ADDR_W-1:0] obi_addr_i,
  input  logic [DATA_W-1:0] obi_wdata_i,
  output logic              obi_gnt_o,
  output logic              obi_rvalid_o,
  output logic [DATA_W-1:0] obi_rdata_o,
  output logic              obi_err_o,
  // AXI write address
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  // AXI write data
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [BE_W-1:0]   m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  // AXI write response
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  // AXI read address
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  // AXI read data
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  // debug view of the tracking state
  output logic [CNT_W-1:0]  dbg_cnt,
  output logic              dbg_dir,
  output logic              dbg_aw_done,
  output logic              dbg_w_done
);

  // Handshake rule: a transfer happens on a channel in a cycle where valid and
  // ready are both high; valid is never withdrawn before ready because OBI holds
  // req and its attributes until gnt, and can_issue cannot fall while waiting.

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_OUT);
  localparam logic [2:0]       SIZE_C = 3'($clog2(BE_W));

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir;
  logic             aw_done;
  logic             w_done;

  logic is_read, is_write, can_issue;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic rd_gnt, wr_gnt, rsp;
  logic unused_ok;

  assign m_axi_awaddr  = obi_addr_i;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = SIZE_C;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = obi_wdata_i;
  assign m_axi_wstrb   = obi_be_i;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_araddr  = obi_addr_i;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = SIZE_C;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arprot  = 3'b000;
  assign obi_rdata_o   = m_axi_rdata;

  assign unused_ok = ^{m_axi_rlast, m_axi_rresp[0], m_axi_bresp[0]};

  always_comb begin
    is_read  = obi_req_i & ~obi_we_i;
    is_write = obi_req_i & obi_we_i;
    // Registered count only, so a response never combinationally opens issue.
    can_issue = ~rst && (cnt < MAX_C) && ((cnt == '0) || (dir == obi_we_i));

    m_axi_arvalid = is_read & can_issue;
    m_axi_awvalid = is_write & can_issue & ~aw_done;
    m_axi_wvalid  = is_write & can_issue & ~w_done;

    ar_hs = m_axi_arvalid & m_axi_arready;
    aw_hs = m_axi_awvalid & m_axi_awready;
    w_hs  = m_axi_wvalid & m_axi_wready;

    rd_gnt    = ar_hs;
    wr_gnt    = is_write & can_issue & (aw_done | aw_hs) & (w_done | w_hs);
    obi_gnt_o = rd_gnt | wr_gnt;

    m_axi_rready = (cnt != '0) & ~dir;
    m_axi_bready = (cnt != '0) & dir;

    r_hs = m_axi_rvalid & m_axi_rready;
    b_hs = m_axi_bvalid & m_axi_bready;
    rsp  = r_hs | b_hs;

    obi_rvalid_o = rsp;
    obi_err_o    = (r_hs & m_axi_rresp[1]) | (b_hs & m_axi_bresp[1]);

    cnt_nxt = cnt;
    if (obi_gnt_o && !rsp) begin
      cnt_nxt = cnt + 1'b1;
    end else if (rsp && !obi_gnt_o) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      dir     <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (obi_gnt_o) begin
        dir <= obi_we_i;
      end
      aw_done <= wr_gnt ? 1'b0 : (aw_done | aw_hs);
      w_done  <= wr_gnt ? 1'b0 : (w_done | w_hs);
    end
  end

  assign dbg_cnt     = cnt;
  assign dbg_dir     = dir;
  assign dbg_aw_done = aw_done;
  assign dbg_w_done  = w_done;

  // Counter stays within 0..MAX_OUT and never wraps below zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt <= MAX_C);
      assert (!(rsp && !obi_gnt_o && cnt == '0));
    end
  end

endmodule

// File: tb/tb_obi_axi_bridge.sv
// Directed bench for obi_axi_bridge (ADDR_W=32, DATA_W=32, MAX_OUT=4).
module tb_obi_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        obi_req_i = 1'b0, obi_we_i = 1'b0;
  logic [3:0]  obi_be_i = 4'h0;
  logic [31:0] obi_addr_i = '0, obi_wdata_i = '0;
  logic        obi_gnt_o, obi_rvalid_o, obi_err_o;
  logic [31:0] obi_rdata_o;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready;
  logic        m_axi_arvalid, m_axi_rready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [2:0]  dbg_cnt;
  logic        dbg_dir, dbg_aw_done, dbg_w_done;

  int total = 0;
  int bad   = 0;

  obi_axi_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .obi_req_i(obi_req_i), .obi_we_i(obi_we_i), .obi_be_i(obi_be_i),
    .obi_addr_i(obi_addr_i), .obi_wdata_i(obi_wdata_i),
    .obi_gnt_o(obi_gnt_o), .obi_rvalid_o(obi_rvalid_o),
    .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_cnt(dbg_cnt), .dbg_dir(dbg_dir), .dbg_aw_done(dbg_aw_done), .dbg_w_done(dbg_w_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // read request driven until granted
  task automatic drive_read(input logic [31:0] addr);
    obi_req_i  = 1'b1;
    obi_we_i   = 1'b0;
    obi_addr_i = addr;
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data);
    obi_req_i   = 1'b1;
    obi_we_i    = 1'b1;
    obi_addr_i  = addr;
    obi_wdata_i = data;
    obi_be_i    = 4'hF;
  endtask

  task automatic r_beat(input logic [31:0] data, input logic [1:0] resp);
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = data;
    m_axi_rresp  = resp;
  endtask

  initial begin
    // reset state with a pending read request
    drive_read(32'h0000_1000);
    m_axi_arready = 1'b1;
    #2;
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_gnt", obi_gnt_o, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_cnt", dbg_cnt, 3'd0);
    chk("awsize", m_axi_awsize, 3'd2);
    chk("arburst", m_axi_arburst, 2'b01);
    chk("awlen", m_axi_awlen, 8'd0);
    chk("wlast", m_axi_wlast, 1'b1);
    tick();
    rst = 1'b0;

    // single read, R beat two cycles after the grant
    settle();
    chk("t1_arvalid", m_axi_arvalid, 1'b1);
    chk("t1_araddr", m_axi_araddr, 32'h0000_1000);
    chk("t1_gnt", obi_gnt_o, 1'b1);
    tick();
    obi_req_i = 1'b0;
    settle();
    chk("t1_rready", m_axi_rready, 1'b1);
    chk("t1_no_rvalid", obi_rvalid_o, 1'b0);
    tick();
    r_beat(32'hDEAD_BEEF, 2'b00);
    settle();
    chk("t1_rvalid", obi_rvalid_o, 1'b1);
    chk("t1_rdata", obi_rdata_o, 32'hDEAD_BEEF);
    chk("t1_err", obi_err_o, 1'b0);
    tick();
    m_axi_rvalid = 1'b0;
    settle();
    chk("t1_cnt", dbg_cnt, 3'd0);

    // write: W accepted at cycle 0, AW only at cycle 3
    drive_write(32'h0000_2000, 32'h1234_5678);
    m_axi_wready = 1'b1;
    settle();
    chk("t2_awvalid0", m_axi_awvalid, 1'b1);
    chk("t2_wvalid0", m_axi_wvalid, 1'b1);
    chk("t2_gnt0", obi_gnt_o, 1'b0);
    tick();
    m_axi_wready = 1'b0;
    settle();
    chk("t2_wvalid1", m_axi_wvalid, 1'b0);
    chk("t2_awvalid1", m_axi_awvalid, 1'b1);
    chk("t2_gnt1", obi_gnt_o, 1'b0);
    tick();
    settle();
    chk("t2_gnt2", obi_gnt_o, 1'b0);
    tick();
    m_axi_awready = 1'b1;
    settle();
    chk("t2_gnt3", obi_gnt_o, 1'b1);
    chk("t2_awaddr", m_axi_awaddr, 32'h0000_2000);
    tick();
    obi_req_i = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = 2'b00;
    settle();
    chk("t2_bready", m_axi_bready, 1'b1);
    chk("t2_rready", m_axi_rready, 1'b0);
    chk("t2_rvalid", obi_rvalid_o, 1'b1);
    chk("t2_err", obi_err_o, 1'b0);
    tick();
    m_axi_bvalid = 1'b0;

    // write with SLVERR, AW and W in the same cycle
    drive_write(32'h0000_2004, 32'hCAFE_0001);
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    settle();
    chk("t5_gnt", obi_gnt_o, 1'b1);
    tick();
    obi_req_i = 1'b0;
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = 2'b10;
    settle();
    chk("t5_bresp_rvalid", obi_rvalid_o, 1'b1);
    chk("t5_bresp_err", obi_err_o, 1'b1);
    tick();
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    settle();
    chk("t5_cnt_after_b", dbg_cnt, 3'd0);

    // spurious responses with nothing outstanding
    m_axi_bvalid = 1'b1;
    r_beat(32'h5555_5555, 2'b00);
    settle();
    chk("sp_bready", m_axi_bready, 1'b0);
    chk("sp_rready", m_axi_rready, 1'b0);
    chk("sp_rvalid", obi_rvalid_o, 1'b0);
    tick();
    m_axi_bvalid = 1'b0;
    m_axi_rvalid = 1'b0;

    // six back-to-back reads against MAX_OUT=4
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_read(32'h0000_3000 + 32'(i * 4));
      settle();
      chk($sformatf("t3_gnt%0d", i), obi_gnt_o, 1'b1);
      tick();
    end
    drive_read(32'h0000_3010);
    settle();
    chk("t3_full_gnt", obi_gnt_o, 1'b0);
    chk("t3_full_arvalid", m_axi_arvalid, 1'b0);
    chk("t3_full_cnt", dbg_cnt, 3'd4);
    tick();
    r_beat(32'hD000_0000, 2'b00);
    settle();
    chk("t3_d0_rvalid", obi_rvalid_o, 1'b1);
    chk("t3_d0_rdata", obi_rdata_o, 32'hD000_0000);
    chk("t3_full_rsp_arvalid", m_axi_arvalid, 1'b0);
    tick();
    m_axi_rvalid = 1'b0;
    settle();
    chk("t3_gnt4", obi_gnt_o, 1'b1);
    tick();
    drive_read(32'h0000_3014);
    settle();
    chk("t3_full2_gnt", obi_gnt_o, 1'b0);
    tick();
    r_beat(32'hD000_0001, 2'b00);
    settle();
    chk("t3_d1_rdata", obi_rdata_o, 32'hD000_0001);
    chk("t3_full2_rsp_gnt", obi_gnt_o, 1'b0);
    tick();
    m_axi_rvalid = 1'b0;
    settle();
    chk("t3_gnt5", obi_gnt_o, 1'b1);
    tick();
    obi_req_i = 1'b0;
    for (int i = 2; i < 6; i++) begin
      r_beat(32'hD000_0000 + 32'(i), 2'b00);
      settle();
      chk($sformatf("t3_drain_rvalid%0d", i), obi_rvalid_o, 1'b1);
      chk($sformatf("t3_drain_rdata%0d", i), obi_rdata_o, 32'hD000_0000 + 32'(i));
      tick();
    end
    m_axi_rvalid = 1'b0;
    settle();
    chk("t3_cnt_end", dbg_cnt, 3'd0);

    // read outstanding blocks a write until the R beat completes
    drive_read(32'h0000_4000);
    settle();
    chk("t4_rd_gnt", obi_gnt_o, 1'b1);
    tick();
    drive_write(32'h0000_4100, 32'hABCD_0000);
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    m_axi_bvalid  = 1'b1;
    settle();
    chk("t4_awvalid_blk", m_axi_awvalid, 1'b0);
    chk("t4_wvalid_blk", m_axi_wvalid, 1'b0);
    chk("t4_gnt_blk", obi_gnt_o, 1'b0);
    chk("t4_wrong_bready", m_axi_bready, 1'b0);
    chk("t4_wrong_rvalid", obi_rvalid_o, 1'b0);
    tick();
    m_axi_bvalid = 1'b0;
    r_beat(32'h0BAD_0BAD, 2'b11);
    settle();
    chk("t4_r_rvalid", obi_rvalid_o, 1'b1);
    chk("t4_decerr", obi_err_o, 1'b1);
    chk("t4_awvalid_rsp", m_axi_awvalid, 1'b0);
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rresp  = 2'b00;
    settle();
    chk("t4_cnt_dec", dbg_cnt, 3'd0);
    chk("t4_awvalid", m_axi_awvalid, 1'b1);
    chk("t4_wvalid", m_axi_wvalid, 1'b1);
    chk("t4_wr_gnt", obi_gnt_o, 1'b1);
    tick();
    obi_req_i = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b1;
    settle();
    chk("t4_b_rvalid", obi_rvalid_o, 1'b1);
    tick();
    m_axi_bvalid = 1'b0;

    // reset with three reads outstanding
    for (int i = 0; i < 3; i++) begin
      drive_read(32'h0000_5000 + 32'(i * 4));
      settle();
      chk($sformatf("t6_gnt%0d", i), obi_gnt_o, 1'b1);
      tick();
    end
    drive_read(32'h0000_500C);
    settle();
    chk("t6_cnt3", dbg_cnt, 3'd3);
    rst = 1'b1;
    settle();
    chk("t6_cnt_rst", dbg_cnt, 3'd0);
    chk("t6_arvalid_rst", m_axi_arvalid, 1'b0);
    chk("t6_gnt_rst", obi_gnt_o, 1'b0);
    chk("t6_rready_rst", m_axi_rready, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    chk("t6_gnt_after", obi_gnt_o, 1'b1);
    chk("t6_araddr_after", m_axi_araddr, 32'h0000_500C);
    tick();
    obi_req_i = 1'b0;
    settle();
    chk("t6_cnt_after", dbg_cnt, 3'd1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "time limit reached");
  end

endmodule
